// File: rtl/pc_sequencer.sv
// Next-PC selection, boot sequencing and trap/return control for fetch.
// Trap support is built only when PCSEQ_TRAP_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter logic [31:0] INC          = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_value,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        trap_req,
  input  logic        eret,
  output logic [31:0] next_pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        trap_ack,
  output logic        misalign,
  output logic [31:0] epc,
  output logic        in_trap
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic        mis_q, mis_d;
  logic        trap_hit;
  logic        eret_hit;
  logic [31:0] epc_w;

`ifdef PCSEQ_TRAP_EN
  logic [31:0] epc_q;
  logic        ack_q;

  assign trap_hit = trap_req & (state_q == RUN);
  assign eret_hit = eret & (state_q == TRAP);
  assign epc_w    = epc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epc_q <= 32'h0;
      ack_q <= 1'b0;
    end else begin
      if (trap_hit) epc_q <= pc_value;
      ack_q <= trap_hit;
    end
  end

  assign trap_ack = ack_q;
  assign epc      = epc_q;
  assign in_trap  = (state_q == TRAP);
`else
  logic unused_trap;
  assign unused_trap = trap_req ^ eret;
  assign trap_hit    = 1'b0;
  assign eret_hit    = 1'b0;
  assign epc_w       = 32'h0;
  assign trap_ack    = 1'b0;
  assign epc         = 32'h0;
  assign in_trap     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    next_pc     = pc_value;
    fetch_valid = 1'b0;
    flush_d     = 1'b0;
    mis_d       = 1'b0;
    case (state_q)
      BOOT: begin
        next_pc = RESET_VECTOR;
        state_d = RUN;
      end
      default: begin
        fetch_valid = 1'b1;
        if (trap_hit) begin
          next_pc = TRAP_VECTOR;
          state_d = TRAP;
          flush_d = 1'b1;
        end else if (eret_hit) begin
          next_pc = epc_w;
          state_d = RUN;
          flush_d = 1'b1;
        end else if (branch_valid) begin
          next_pc = {branch_target[31:2], 2'b00};
          flush_d = 1'b1;
          mis_d   = |branch_target[1:0];
        end else if (jump_valid) begin
          next_pc = {jump_target[31:2], 2'b00};
          flush_d = 1'b1;
          mis_d   = |jump_target[1:0];
        end else if (stall || !fetch_ready) begin
          next_pc = pc_value;
        end else begin
          next_pc = pc_value + INC;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign flush    = flush_q;
  assign misalign = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: owns the PC register and checks every cycle
// against a rule-level model, directed steps then random traffic.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
`ifdef PCSEQ_TRAP_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic        fetch_ready = 1'b0;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump_valid = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        trap_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] next_pc;
  logic        fetch_valid;
  logic        flush;
  logic        trap_ack;
  logic        misalign;
  logic [31:0] epc;
  logic        in_trap;

  int vectors = 0;
  int miscompares = 0;

  bit          m_run, m_trap, m_flush, m_ack, m_mis;
  logic [31:0] m_pc, m_epc;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .pc_value(pc),
    .fetch_ready(fetch_ready), .stall(stall),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .trap_req(trap_req), .eret(eret),
    .next_pc(next_pc), .fetch_valid(fetch_valid),
    .flush(flush), .trap_ack(trap_ack), .misalign(misalign),
    .epc(epc), .in_trap(in_trap)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) pc <= RV;
    else pc <= next_pc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit fr,
                     input bit bv, input logic [31:0] bt,
                     input bit jv, input logic [31:0] jt,
                     input bit tr, input bit er);
    logic [31:0] e_next;
    bit e_fv, n_run, n_trap, n_flush, n_ack, n_mis;
    logic [31:0] n_epc;
    @(negedge clk);
    rst = r; stall = s; fetch_ready = fr;
    branch_valid = bv; branch_target = bt;
    jump_valid = jv; jump_target = jt;
    trap_req = tr; eret = er;
    #1;
    if (!r) begin
      m_run = 0; m_trap = 0; m_epc = 0;
      m_flush = 0; m_ack = 0; m_mis = 0; m_pc = RV;
    end
    n_run = m_run; n_trap = m_trap; n_epc = m_epc;
    n_flush = 0; n_ack = 0; n_mis = 0;
    e_next = RV; e_fv = 0;
    if (r && !m_run) begin
      n_run = 1;
    end else if (r) begin
      e_fv = 1;
      if (TEN && tr && !m_trap) begin
        e_next = TV; n_epc = m_pc; n_trap = 1;
        n_flush = 1; n_ack = 1;
      end else if (TEN && er && m_trap) begin
        e_next = m_epc; n_trap = 0; n_flush = 1;
      end else if (bv) begin
        e_next = bt & ~32'h3; n_flush = 1; n_mis = (bt % 4) != 0;
      end else if (jv) begin
        e_next = jt & ~32'h3; n_flush = 1; n_mis = (jt % 4) != 0;
      end else if (s || !fr) begin
        e_next = m_pc;
      end else begin
        e_next = m_pc + 32'd4;
      end
    end
    chk("pc", pc, m_pc);
    chk("next_pc", next_pc, e_next);
    chk("fetch_valid", {31'h0, fetch_valid}, {31'h0, e_fv});
    chk("flush", {31'h0, flush}, {31'h0, m_flush});
    chk("trap_ack", {31'h0, trap_ack}, {31'h0, m_ack});
    chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
    chk("epc", epc, TEN ? m_epc : 32'h0);
    chk("in_trap", {31'h0, in_trap}, {31'h0, TEN & m_trap});
    vectors++;
    @(posedge clk);
    if (r) begin
      m_pc = e_next; m_run = n_run; m_trap = n_trap; m_epc = n_epc;
      m_flush = n_flush; m_ack = n_ack; m_mis = n_mis;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jmp(input logic [31:0] t);
    cyc(1, 0, 1, 0, 0, 1, t, 0, 0);
  endtask

  initial begin
    m_run = 0; m_trap = 0; m_epc = 0; m_pc = RV;
    m_flush = 0; m_ack = 0; m_mis = 0;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    run(4);
    jmp(32'h10);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
    run(2);
    jmp(32'h10);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    run(2);
    cyc(1, 1, 1, 1, 32'h203, 0, 0, 0, 0);
    run(2);
    jmp(32'h40);
    cyc(1, 0, 1, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 1, 0);
    run(1);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 1);
    run(2);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 1);
    jmp(32'hFFFF_FFFC);
    run(3);
    cyc(1, 0, 1, 1, 32'h300, 0, 0, 1, 0);
    run(1);
    cyc(1, 0, 1, 0, 0, 1, 32'h500, 1, 0);
    run(2);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    run(3);
    for (int i = 0; i < 500; i++) begin
      bit r, s, fr, bv, jv, tr, er;
      logic [31:0] bt, jt;
      r  = $urandom_range(0, 60) != 0;
      s  = $urandom_range(0, 4) == 0;
      fr = $urandom_range(0, 5) != 0;
      bv = $urandom_range(0, 7) == 0;
      jv = $urandom_range(0, 7) == 0;
      tr = $urandom_range(0, 12) == 0;
      er = $urandom_range(0, 5) == 0;
      bt = $urandom;
      jt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      cyc(r, s, fr, bv, bt, jv, jt, tr, er);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
